// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier: one partial product per clock, start/ready/done handshake.
// Optional macro SEQ_MULT_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are all zero.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_next;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [CW-1:0]        count_r;
  logic [2*WIDTH-1:0]   sum_s;
  logic                 last_s;

  assign sum_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

  // Decide whether the current RUN edge performs the final iteration
  always_comb begin
    last_s = 1'b0;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    if ((mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}}) || (count_r == CW'(WIDTH - 1))) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
`else
    if (count_r == CW'(WIDTH - 1)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
`endif
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add iteration and result register
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      count_r  <= {CW{1'b0}};
      product  <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, A};
            mplier_r <= B;
            count_r  <= {CW{1'b0}};
          end
        end
        RUN: begin
          acc_r    <= sum_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + CW'(1);
          if (last_s) begin
            product <= sum_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake outputs come straight from the state register
  assign ready = (state_r == IDLE);
  assign done  = (state_r == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed and random multiplies against an arithmetic reference.
module tb_seq_multiplier;

  localparam int W = 8;

  logic             clock;
  logic             reset;
  logic             start;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic             ready;
  logic             done;
  logic [2*W-1:0]   product;

  int tests;
  int fails;
  logic [2*W-1:0] last_product;

  seq_multiplier #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .A       (A),
    .B       (B),
    .ready   (ready),
    .done    (done),
    .product (product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Number of RUN cycles the reference expects for multiplier b
  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    int l;
    l = 1;
    for (int i = 0; i < W; i++) begin
      if (b[i]) l = i + 1;
    end
    return l;
`else
    return W;
`endif
  endfunction

  // One full multiply; with noise, start/A/B are scrambled while the block is busy
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    logic [2*W-1:0] expv;
    int lat;
    expv = (2*W)'(a) * (2*W)'(b);
    lat  = exp_lat(b);
    check("ready_before_start", 32'(ready), 32'd1);
    start = 1'b1;
    A = a;
    B = b;
    step();
    for (int k = 1; k <= lat; k++) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      A = W'($urandom);
      B = W'($urandom);
      step();
      if (k < lat) begin
        check("ready_in_run", 32'(ready), 32'd0);
        check("done_in_run", 32'(done), 32'd0);
        check("product_stable_run", 32'(product), 32'(last_product));
      end else begin
        check("done_pulse", 32'(done), 32'd1);
        check("ready_in_done", 32'(ready), 32'd0);
        check("product_result", 32'(product), 32'(expv));
      end
    end
    start = noise ? 1'b1 : 1'b0;
    step();
    start = 1'b0;
    check("ready_after_done", 32'(ready), 32'd1);
    check("done_after_done", 32'(done), 32'd0);
    check("product_hold", 32'(product), 32'(expv));
    last_product = expv;
  endtask

  initial begin
    int lat;
    tests = 0;
    fails = 0;
    last_product = '0;
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    step();
    step();
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    reset = 1'b0;
    step();
    check("idle_ready", 32'(ready), 32'd1);

    // Basic and extreme operands
    run_mult(8'd3, 8'd5, 1'b0);
    run_mult(8'd255, 8'd255, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_hold_ff", 32'(product), 32'(last_product));
    end
    run_mult(8'd128, 8'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_hold_256", 32'(product), 32'(last_product));
    end

    // Start while busy is ignored
    run_mult(8'd7, 8'd9, 1'b1);

    // Reset mid-RUN aborts
    start = 1'b1;
    A = 8'd10;
    B = 8'd12;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    last_product = '0;
    run_mult(8'd2, 8'd3, 1'b0);

    // Reset in DONE
    lat = exp_lat(8'd11);
    start = 1'b1;
    A = 8'd13;
    B = 8'd11;
    step();
    start = 1'b0;
    for (int i = 0; i < lat; i++) step();
    check("done_before_reset", 32'(done), 32'd1);
    check("product_before_reset", 32'(product), 32'd143);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_done_ready", 32'(ready), 32'd1);
    check("rst_done_done", 32'(done), 32'd0);
    check("rst_done_product", 32'(product), 32'd0);
    last_product = '0;

    // Reset and start on the same edge: request dropped
    reset = 1'b1;
    start = 1'b1;
    A = 8'd9;
    B = 8'd9;
    step();
    reset = 1'b0;
    start = 1'b0;
    step();
    check("rst_start_ready", 32'(ready), 32'd1);
    check("rst_start_product", 32'(product), 32'd0);

    // Zero operands and early-exit timing cases
    run_mult(8'd200, 8'd0, 1'b0);
    run_mult(8'd0, 8'd77, 1'b0);
    run_mult(8'd5, 8'd3, 1'b0);

    // Random operands with busy-time noise
    for (int n = 0; n < 25; n++) begin
      run_mult(W'($urandom), W'($urandom), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
